// File: rtl/histo_pkg.sv
// Shared definitions for the histogram/CDF engine: state encoding and saturating add.
package histo_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR   = 2'd0,
    ST_IDLE    = 2'd1,
    ST_ACCUM   = 2'd2,
    ST_PUBLISH = 2'd3
  } state_t;

  localparam int unsigned SAT_W  = 32;
  localparam int unsigned SAT_W1 = SAT_W + 1;

  // Unsigned a+b clamped to 2**w-1; callers pass operands zero-extended to SAT_W, w <= SAT_W.
  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                               input logic [SAT_W-1:0] b,
                                               input int unsigned      w);
    logic [SAT_W1-1:0] sum;
    logic [SAT_W1-1:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (SAT_W1'(1) << w) - SAT_W1'(1);
    return (sum > lim) ? lim[SAT_W-1:0] : sum[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/histo_dpram.sv
// Simple dual-port RAM: one write port, one registered read port, old data on collision.
module histo_dpram #(
  parameter int unsigned W     = 20,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/histo_cdf_engine.sv
// Per-frame grey histogram with saturating CDF, published to display RAMs at frame end,
// plus bar-graph overlay outputs and frame statistics.
module histo_cdf_engine
  import histo_pkg::*;
#(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned CNT_W = 20,
  parameter int unsigned X_W   = 16,
  parameter int unsigned SHIFT = 0
) (
  input  logic             iPclk,
  input  logic             iRst_n,
  input  logic             iFval,
  input  logic             iDval,
  input  logic [PIX_W-1:0] iGrey,
  input  logic [PIX_W-1:0] iRd_bin,
  input  logic [X_W-1:0]   iX_cont,
  output logic [7:0]       oGr_Out_His,
  output logic [7:0]       oGr_Out_Cum,
  output logic [CNT_W-1:0] oHis_max,
  output logic [CNT_W-1:0] oTotal,
  output logic             oFrame_done,
  output logic [1:0]       oState
);

  localparam int unsigned NBINS  = 1 << PIX_W;
  localparam int unsigned ADDR_W = PIX_W + 1;
  localparam int unsigned CMP_W  = (CNT_W > X_W) ? CNT_W : X_W;

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    return CNT_W'(sat_add(SAT_W'(a), SAT_W'(b), CNT_W));
  endfunction

  state_t              r_state, w_next;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic                r_fval_d;
  logic                w_rise, w_fall, w_take, w_pub_last;

  logic                r_s1_vld;
  logic [PIX_W-1:0]    r_s1_bin;
  logic                r_fw_vld;
  logic [PIX_W-1:0]    r_fw_bin;
  logic [CNT_W-1:0]    r_fw_data;
  logic [CNT_W-1:0]    w_cnt, w_inc;

  logic                r_pub_vld;
  logic [PIX_W-1:0]    r_pub_bin;
  logic [CNT_W-1:0]    r_run, r_max, w_pub_sum, w_pub_max;

  logic                w_work_we, w_disp_we;
  logic [PIX_W-1:0]    w_work_waddr, w_work_raddr, w_disp_waddr;
  logic [CNT_W-1:0]    w_work_wdata, w_disp_wdata, w_cum_wdata;
  logic [CNT_W-1:0]    w_work_q, w_disp_q, w_cum_q;

  logic [X_W-1:0]      r_x_d1;
  logic [7:0]          r_gr_his, r_gr_cum;
  logic [CNT_W-1:0]    r_his_max, r_total;
  logic                r_frame_done;

  assign w_rise = iFval & ~r_fval_d;
  assign w_fall = ~iFval & r_fval_d;
  // The rising-edge cycle already belongs to the frame, so its pixel is counted.
  assign w_take = iFval & iDval &
                  ((r_state == ST_ACCUM) || ((r_state == ST_IDLE) && w_rise));

  // Distance-1 forwarding hides the RAM's old-data-on-collision behaviour.
  assign w_cnt     = (r_fw_vld && (r_fw_bin == r_s1_bin)) ? r_fw_data : w_work_q;
  assign w_inc     = sat_cnt(w_cnt, CNT_W'(1));
  assign w_pub_sum = sat_cnt(r_run, w_work_q);
  assign w_pub_max = (w_work_q > r_max) ? w_work_q : r_max;

  always_ff @(posedge iPclk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state  <= ST_CLEAR;
      r_addr   <= '0;
      r_fval_d <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_addr   <= w_addr_nxt;
      r_fval_d <= iFval;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_addr_nxt = r_addr;
    w_pub_last = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_addr_nxt = r_addr + ADDR_W'(1);
        if (r_addr == ADDR_W'(NBINS - 1)) begin
          w_next     = ST_IDLE;
          w_addr_nxt = '0;
        end
      end
      ST_IDLE: begin
        if (w_rise) w_next = ST_ACCUM;
      end
      ST_ACCUM: begin
        // The fall cycle itself drains the last stage-1 write.
        if (w_fall) begin
          w_next     = ST_PUBLISH;
          w_addr_nxt = '0;
        end
      end
      ST_PUBLISH: begin
        w_addr_nxt = r_addr + ADDR_W'(1);
        if (r_addr == ADDR_W'(NBINS)) begin
          w_next     = ST_IDLE;
          w_addr_nxt = '0;
          w_pub_last = 1'b1;
        end
      end
      default: w_next = ST_CLEAR;
    endcase
  end

  // RAM port steering: sweep clear, accumulate write-back, publish copy-and-clear.
  always_comb begin
    w_work_we    = 1'b0;
    w_work_waddr = '0;
    w_work_wdata = '0;
    w_work_raddr = iGrey;
    w_disp_we    = 1'b0;
    w_disp_waddr = '0;
    w_disp_wdata = '0;
    w_cum_wdata  = '0;
    if (r_state == ST_CLEAR) begin
      w_work_we    = 1'b1;
      w_work_waddr = r_addr[PIX_W-1:0];
      w_disp_we    = 1'b1;
      w_disp_waddr = r_addr[PIX_W-1:0];
    end else if (r_pub_vld) begin
      w_work_we    = 1'b1;
      w_work_waddr = r_pub_bin;
      w_disp_we    = 1'b1;
      w_disp_waddr = r_pub_bin;
      w_disp_wdata = w_work_q;
      w_cum_wdata  = w_pub_sum;
    end else if (r_s1_vld) begin
      w_work_we    = 1'b1;
      w_work_waddr = r_s1_bin;
      w_work_wdata = w_inc;
    end
    if (r_state == ST_PUBLISH) w_work_raddr = r_addr[PIX_W-1:0];
  end

  always_ff @(posedge iPclk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_s1_vld  <= 1'b0;
      r_s1_bin  <= '0;
      r_fw_vld  <= 1'b0;
      r_fw_bin  <= '0;
      r_fw_data <= '0;
    end else begin
      r_s1_vld  <= w_take;
      r_s1_bin  <= iGrey;
      r_fw_vld  <= r_s1_vld && (r_state != ST_CLEAR);
      r_fw_bin  <= r_s1_bin;
      r_fw_data <= w_inc;
    end
  end

  always_ff @(posedge iPclk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_pub_vld    <= 1'b0;
      r_pub_bin    <= '0;
      r_run        <= '0;
      r_max        <= '0;
      r_his_max    <= '0;
      r_total      <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_pub_vld    <= (r_state == ST_PUBLISH) && (r_addr < ADDR_W'(NBINS));
      r_pub_bin    <= r_addr[PIX_W-1:0];
      r_frame_done <= w_pub_last;
      if ((r_state == ST_ACCUM) && w_fall) begin
        r_run <= '0;
        r_max <= '0;
      end else if (r_pub_vld) begin
        r_run <= w_pub_sum;
        r_max <= w_pub_max;
      end
      if (w_pub_last) begin
        r_his_max <= w_pub_max;
        r_total   <= w_pub_sum;
      end
    end
  end

  // Display path: RAM read then registered bar compare, 2-cycle latency.
  always_ff @(posedge iPclk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_x_d1   <= '0;
      r_gr_his <= '0;
      r_gr_cum <= '0;
    end else begin
      r_x_d1   <= iX_cont;
      r_gr_his <= (CMP_W'(w_disp_q >> SHIFT) > CMP_W'(r_x_d1)) ? 8'hFF : 8'h00;
      r_gr_cum <= (CMP_W'(w_cum_q >> SHIFT) > CMP_W'(r_x_d1)) ? 8'hFF : 8'h00;
    end
  end

  histo_dpram #(.W(CNT_W), .DEPTH(NBINS), .AW(PIX_W)) u_work (
    .clk(iPclk), .i_we(w_work_we), .i_waddr(w_work_waddr), .i_wdata(w_work_wdata),
    .i_raddr(w_work_raddr), .o_rdata(w_work_q)
  );

  histo_dpram #(.W(CNT_W), .DEPTH(NBINS), .AW(PIX_W)) u_disp (
    .clk(iPclk), .i_we(w_disp_we), .i_waddr(w_disp_waddr), .i_wdata(w_disp_wdata),
    .i_raddr(iRd_bin), .o_rdata(w_disp_q)
  );

  histo_dpram #(.W(CNT_W), .DEPTH(NBINS), .AW(PIX_W)) u_cum (
    .clk(iPclk), .i_we(w_disp_we), .i_waddr(w_disp_waddr), .i_wdata(w_cum_wdata),
    .i_raddr(iRd_bin), .o_rdata(w_cum_q)
  );

  assign oGr_Out_His = r_gr_his;
  assign oGr_Out_Cum = r_gr_cum;
  assign oHis_max    = r_his_max;
  assign oTotal      = r_total;
  assign oFrame_done = r_frame_done;
  assign oState      = r_state;

endmodule

// File: tb/tb_histo_cdf_engine.sv
// Bench for histo_cdf_engine: three parameterisations driven in lockstep, checked against
// a frame-level histogram/CDF model through the bar-graph outputs and frame statistics.
module tb_histo_cdf_engine;

  localparam int NB = 256;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       iFval, iDval;
  logic [7:0] iGrey, iRd_bin;
  logic [15:0] iX_cont;

  logic [7:0]  his [3];
  logic [7:0]  cum [3];
  logic        done [3];
  logic [1:0]  st [3];
  logic [19:0] max0, tot0, max1, tot1;
  logic [3:0]  max2, tot2;

  histo_cdf_engine u_d0 (
    .iPclk(clk), .iRst_n(rst_n), .iFval(iFval), .iDval(iDval), .iGrey(iGrey),
    .iRd_bin(iRd_bin), .iX_cont(iX_cont), .oGr_Out_His(his[0]), .oGr_Out_Cum(cum[0]),
    .oHis_max(max0), .oTotal(tot0), .oFrame_done(done[0]), .oState(st[0])
  );
  histo_cdf_engine #(.SHIFT(1)) u_d1 (
    .iPclk(clk), .iRst_n(rst_n), .iFval(iFval), .iDval(iDval), .iGrey(iGrey),
    .iRd_bin(iRd_bin), .iX_cont(iX_cont), .oGr_Out_His(his[1]), .oGr_Out_Cum(cum[1]),
    .oHis_max(max1), .oTotal(tot1), .oFrame_done(done[1]), .oState(st[1])
  );
  histo_cdf_engine #(.CNT_W(4)) u_d2 (
    .iPclk(clk), .iRst_n(rst_n), .iFval(iFval), .iDval(iDval), .iGrey(iGrey),
    .iRd_bin(iRd_bin), .iX_cont(iX_cont), .oGr_Out_His(his[2]), .oGr_Out_Cum(cum[2]),
    .oHis_max(max2), .oTotal(tot2), .oFrame_done(done[2]), .oState(st[2])
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: raw pixel counts of the frame being built, published views per instance.
  int cw [3] = '{20, 20, 4};
  int sh [3] = '{0, 1, 0};
  longint raw [NB];
  longint mh [3][NB];
  longint mc [3][NB];
  longint mmax [3];
  longint mtot [3];

  int pq [$];
  int gq [$];

  typedef struct {
    int bin;
    int x;
    int eh;
    int ec;
    int esh;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int g = 0; g < NB; g++) begin
      raw[g] = 0;
      for (int i = 0; i < 3; i++) begin
        mh[i][g] = 0;
        mc[i][g] = 0;
      end
    end
    for (int i = 0; i < 3; i++) begin
      mmax[i] = 0;
      mtot[i] = 0;
    end
  endtask

  task automatic model_publish();
    for (int i = 0; i < 3; i++) begin
      longint lim, run, mx, h;
      lim = (longint'(1) << cw[i]) - 1;
      run = 0;
      mx  = 0;
      for (int g = 0; g < NB; g++) begin
        h = (raw[g] > lim) ? lim : raw[g];
        run = (run + h > lim) ? lim : run + h;
        mh[i][g] = h;
        mc[i][g] = run;
        if (h > mx) mx = h;
      end
      mmax[i] = mx;
      mtot[i] = run;
    end
    for (int g = 0; g < NB; g++) raw[g] = 0;
  endtask

  task automatic chk_stats();
    chk("his_max0", max0, mmax[0]);
    chk("total0", tot0, mtot[0]);
    chk("his_max1", max1, mmax[1]);
    chk("total1", tot1, mtot[1]);
    chk("his_max2", max2, mmax[2]);
    chk("total2", tot2, mtot[2]);
    chk("done1_sync", done[1], 1);
    chk("done2_sync", done[2], 1);
    chk("state_after_publish", st[0], 1);
  endtask

  task automatic send_frame(input bit counted);
    @(negedge clk);
    iFval = 1'b1;
    iDval = 1'b0;
    for (int i = 0; i < pq.size(); i++) begin
      for (int g = 0; g < gq[i]; g++) begin
        @(negedge clk);
        iDval = 1'b0;
      end
      @(negedge clk);
      iDval = 1'b1;
      iGrey = 8'(pq[i]);
      if (counted) raw[pq[i]]++;
    end
    @(negedge clk);
    iDval = 1'b0;
    @(negedge clk);
    iFval = 1'b0;
  endtask

  task automatic wait_done();
    int lat;
    lat = 0;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      if (done[0]) begin
        lat = c;
        break;
      end
    end
    chk("done_latency", lat, 258);
    model_publish();
    chk_stats();
    @(negedge clk);
    chk("done_pulse_width", done[0], 0);
  endtask

  task automatic check_probe(input int k, input int x);
    for (int i = 0; i < 3; i++) begin
      longint eh, ec;
      eh = ((mh[i][k] >> sh[i]) > x) ? 255 : 0;
      ec = ((mc[i][k] >> sh[i]) > x) ? 255 : 0;
      if (his[i] != 8'(eh)) chk($sformatf("his%0d_bin%0d_x%0d", i, k, x), his[i], eh);
      else chk("his", his[i], eh);
      if (cum[i] != 8'(ec)) chk($sformatf("cum%0d_bin%0d_x%0d", i, k, x), cum[i], ec);
      else chk("cum", cum[i], ec);
    end
  endtask

  // Probes every bin just below and at each instance's displayed value.
  task automatic sweep();
    int pb [$];
    int px [$];
    for (int k = 0; k < NB; k++) begin
      for (int i = 0; i < 3; i++) begin
        int vh, vc;
        vh = int'(mh[i][k] >> sh[i]);
        vc = int'(mc[i][k] >> sh[i]);
        pb.push_back(k); px.push_back((vh == 0) ? 0 : vh - 1);
        pb.push_back(k); px.push_back(vh);
        pb.push_back(k); px.push_back((vc == 0) ? 0 : vc - 1);
        pb.push_back(k); px.push_back(vc);
      end
    end
    for (int i = 0; i < pb.size() + 2; i++) begin
      @(negedge clk);
      if (i >= 2) check_probe(pb[i-2], px[i-2]);
      if (i < pb.size()) begin
        iRd_bin = 8'(pb[i]);
        iX_cont = 16'(px[i]);
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (st[0] != 2'd1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_idle", st[0], 1);
  endtask

  initial begin
    int n, lat;
    tbl[0] = '{5,   9,  255, 255, 0};
    tbl[1] = '{5,   10, 0,   0,   0};
    tbl[2] = '{5,   4,  255, 255, 255};
    tbl[3] = '{5,   5,  255, 255, 0};
    tbl[4] = '{4,   0,  0,   0,   0};
    tbl[5] = '{200, 9,  0,   255, 0};
    tbl[6] = '{200, 10, 0,   0,   0};
    tbl[7] = '{255, 0,  0,   255, 0};

    rst_n = 1'b0; iFval = 1'b0; iDval = 1'b0; iGrey = '0; iRd_bin = '0; iX_cont = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_state", st[0], 0);
    chk("rst_his", his[0], 0);
    chk("rst_cum", cum[0], 0);
    chk("rst_max", max0, 0);
    chk("rst_total", tot0, 0);
    chk("rst_done", done[0], 0);
    rst_n = 1'b1;
    n = 0;
    while (st[0] == 2'd0 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk("clear_cycles", n, 256);
    chk("idle_after_clear", st[0], 1);
    sweep();

    // Ten consecutive pixels of grey 5
    pq = {}; gq = {};
    for (int i = 0; i < 10; i++) begin pq.push_back(5); gq.push_back(0); end
    send_frame(1'b1);
    wait_done();
    chk("g5_max", max0, 10);
    chk("g5_total", tot0, 10);
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      iRd_bin = 8'(tbl[v].bin);
      iX_cont = 16'(tbl[v].x);
      @(negedge clk);
      @(negedge clk);
      chk($sformatf("tbl%0d_his", v), his[0], tbl[v].eh);
      chk($sformatf("tbl%0d_cum", v), cum[0], tbl[v].ec);
      chk($sformatf("tbl%0d_his_shift", v), his[1], tbl[v].esh);
    end

    // Forwarding and distance-2 paths: 3,3,_,7,_,3,3
    pq = '{3, 3, 7, 3, 3};
    gq = '{0, 0, 1, 1, 0};
    send_frame(1'b1);
    wait_done();
    chk("fwd_max", max0, 4);
    chk("fwd_total", tot0, 5);
    sweep();

    // Saturation at CNT_W=4
    pq = {}; gq = {};
    for (int i = 0; i < 20; i++) begin pq.push_back(0); gq.push_back(0); end
    send_frame(1'b1);
    wait_done();
    chk("sat_c4_max", max2, 15);
    chk("sat_c4_total", tot2, 15);
    chk("sat_c20_total", tot0, 20);
    sweep();

    // Random frames over narrow, mid and full grey ranges
    for (int f = 0; f < 3; f++) begin
      int gmax, np;
      gmax = (f == 0) ? 3 : ((f == 1) ? 40 : 255);
      np = int'($urandom_range(30, 120));
      pq = {}; gq = {};
      for (int i = 0; i < np; i++) begin
        pq.push_back(int'($urandom_range(0, gmax)));
        gq.push_back(int'($urandom_range(0, 2)));
      end
      send_frame(1'b1);
      wait_done();
      sweep();
    end

    // Frame opening during PUBLISH and still open at publish end is never counted
    pq = {}; gq = {};
    for (int i = 0; i < 6; i++) begin pq.push_back(int'($urandom_range(0, 255))); gq.push_back(0); end
    send_frame(1'b1);
    lat = 0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (done[0] && lat == 0) begin
        lat = c;
        model_publish();
        chk_stats();
      end
      if (c == 20) iFval = 1'b1;
      iDval = (c > 20 && (c % 30) == 0) ? 1'b1 : 1'b0;
      iGrey = 8'd7;
    end
    chk("pub_rise_latency", lat, 258);
    @(negedge clk);
    iDval = 1'b0;
    iFval = 1'b0;
    repeat (5) @(negedge clk);
    chk("ignored_frame_state", st[0], 1);
    pq = '{9, 9, 9};
    gq = '{0, 1, 0};
    send_frame(1'b1);
    wait_done();
    chk("after_ignore_total", tot0, 3);
    chk("after_ignore_max", max0, 3);
    sweep();

    // Reset in the middle of accumulation
    pq = {}; gq = {};
    @(negedge clk);
    iFval = 1'b1;
    repeat (3) @(negedge clk);
    iDval = 1'b1;
    iGrey = 8'd9;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_state", st[0], 0);
    chk("midrst_max", max0, 0);
    chk("midrst_total", tot0, 0);
    iDval = 1'b0;
    iFval = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    wait_idle();
    sweep();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/histo_cdf_engine.md
Name: histo_cdf_engine

Overview:
- Parametrised successor to the single-channel pixel histogram.
- Accumulates a grey-level histogram over each frame (while Fval is high) in a working RAM.
- At frame end, publishes the histogram and its saturating cumulative sum (CDF) to display RAMs, and clears the working RAM in the same sweep.
- Drives per-pixel bar-graph outputs for the VGA overlay and frame statistics (max bin, total) for downstream equalisation.

Parameters:
PIX_W, 8, grey width; NBINS = 2**PIX_W bins
CNT_W, 20, bin counter width; all counts saturate at 2**CNT_W-1
X_W, 16, display coordinate width
SHIFT, 0, right-shift applied to display values before the bar compare (vertical scaling)

Ports:
iPclk  in  1  pixel clock; all logic on rising edge
iRst_n  in  1  asynchronous active-low reset
iFval  in  1  frame valid
iDval  in  1  pixel valid; qualified by iFval
iGrey  in  PIX_W  pixel grey level
iRd_bin  in  PIX_W  display bin select (row index from the VGA side)
iX_cont  in  X_W  display column
oGr_Out_His  out  8  histogram bar pixel, 8'hFF or 8'h00
oGr_Out_Cum  out  8  CDF bar pixel, 8'hFF or 8'h00
oHis_max  out  CNT_W  largest bin of the last published frame
oTotal  out  CNT_W  final CDF value of the last published frame
oFrame_done  out  1  one-cycle pulse when publish completes
oState  out  2  current state encoding

Behaviour:
- Reset (async assert, sync release): state=CLEAR, sweep address 0, all registered outputs 0, oFrame_done 0.
- CLEAR (0): writes 0 to bins 0..NBINS-1 in the working, display and CDF RAMs, one bin per cycle (NBINS cycles), then goes to IDLE. iFval is ignored during CLEAR.
- IDLE (1): on a rising edge of iFval, go to ACCUM. If iFval is already high on entry to IDLE, wait for the next rising edge; a partial frame is never counted.
- ACCUM (2): two-stage read-modify-write pipeline.
  - Stage 0: when iDval & iFval, read address = iGrey.
  - Stage 1 (next cycle): write bin = cnt+1, saturating.
  - cnt = value written by stage 1 in the previous cycle if the bin matches that write (forwarding), otherwise the RAM q.
  - The RAM returns old data on a same-cycle read/write collision; forwarding covers only the distance-1 case, and distance ≥2 reads see the write.
- Falling edge of iFval → PUBLISH after the stage-1 pipeline drains (one cycle).
- PUBLISH (3): for k = 0..NBINS-1, one per cycle.
  - Read work[k]; on the next cycle write disp[k]=q, cum[k]=sat(run+q), and work[k]=0.
  - Update run and the max tracker.
  - Run and max are zeroed at PUBLISH entry.
  - Duration is NBINS+1 cycles.
  - After the last write, oHis_max and oTotal load and oFrame_done pulses for 1 cycle; state goes to IDLE.
- iFval rising during PUBLISH: that frame is ignored (IDLE rule); publish is never aborted.
- Display path: always active and independent of state.
  - Read disp and cum at iRd_bin; iX_cont is delayed to align.
  - Outputs registered, latency 2 cycles from iRd_bin/iX_cont.
  - oGr_Out_His = ((disp>>SHIFT) > x_d2) ? 8'hFF : 8'h00; oGr_Out_Cum is the same using cum.
  - Compare widths are zero-extended to max(CNT_W, X_W).
  - During PUBLISH, the display may show mixed old/new bins (accepted tearing).
- Reset mid-operation: any state returns to CLEAR; display RAMs are re-zeroed.

Decomposition:
- Package histo_pkg: state encoding (CLEAR=0, IDLE=1, ACCUM=2, PUBLISH=3) and a saturating-add function parameterised by width.
- Sub-module histo_dpram: simple dual-port RAM, width CNT_W, depth NBINS, 1-cycle registered read, old-data on collision. Instantiated three times (work, disp, cum).

Test Plan:
- Reset, release → oState=0 for 256 cycles, then 1; iRd_bin=any, iX_cont=0 → oGr_Out_His=00, oGr_Out_Cum=00 two cycles later.
- Frame of 10 consecutive pixels grey 5 → hist[5]=10; cum[k]=0 for k<5 and 10 for k≥5; oHis_max=10, oTotal=10; oFrame_done pulses 258 cycles after the iFval fall.
- Pixels 3,3,7,3,3 with one-cycle iDval gaps between the 7 and its neighbours → hist[3]=4, hist[7]=1 (forwarding and distance-2 paths).
- CNT_W=4, 20 pixels grey 0 → hist[0]=15, cum[255]=15, no wrap.
- iFval rises during PUBLISH with 8 pixels, then a next frame of 3 pixels of grey 9 → published hist[9]=3, oTotal=3.
- hist[5]=10, SHIFT=0, iRd_bin=5: iX_cont=9 → 8'hFF at t+2; iX_cont=10 → 8'h00. With SHIFT=1, iX_cont=4 → FF and iX_cont=5 → 00.
